// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch path: access-size codes, reset PC,
// fetch FSM state encoding and instruction size.
package mips_pkg;

  localparam logic [1:0]  ACC_WORD   = 2'b00;
  localparam logic [31:0] RESET_PC   = 32'h8002_0000;
  localparam int          INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: loads RESET_PC on reset, advances by one instruction
// on request and takes a word-aligned redirect target (redirect has priority).
module fetch_pc #(
  parameter int                      ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = ADDRESS_SIZE'(mips_pkg::RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [ADDRESS_SIZE-1:0] target_i,
  input  logic                    inc_i,
  output logic [ADDRESS_SIZE-1:0] pc_o
);
  import mips_pkg::*;

  logic [ADDRESS_SIZE-1:0] pc_q;
  logic [ADDRESS_SIZE-1:0] pc_d;

  // Next PC: aligned redirect wins over sequential increment (wraps modulo 2^N).
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ~ADDRESS_SIZE'(3);
    end else if (inc_i) begin
      pc_d = pc_q + ADDRESS_SIZE'(INST_BYTES);
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues single-word reads at the PC, returns fetched
// words to decode over a valid/stall handshake and handles branch redirects,
// dropping any read that was already in flight when the redirect arrived.
module inst_fetch #(
  parameter int                      ADDRESS_SIZE = 32,
  parameter int                      DATA_SIZE    = 32,
  parameter int                      ACCESS_SIZE  = 2,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = ADDRESS_SIZE'(mips_pkg::RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy,
  input  logic                    br_taken,
  input  logic [ADDRESS_SIZE-1:0] br_target,
  input  logic                    dec_stall,
  output logic                    inst_valid,
  output logic [DATA_SIZE-1:0]    inst,
  output logic [ADDRESS_SIZE-1:0] inst_pc
);
  import mips_pkg::*;

  fetch_state_e            state_q, state_d;
  logic                    squash_q, squash_d;
  logic                    valid_q, valid_d;
  logic [DATA_SIZE-1:0]    inst_q, inst_d;
  logic [ADDRESS_SIZE-1:0] inst_pc_q, inst_pc_d;
  // Word returned while decode still holds the previous one; parked here so the
  // visible output never changes under dec_stall.
  logic [DATA_SIZE-1:0]    hold_q, hold_d;
  logic [ADDRESS_SIZE-1:0] hold_pc_q, hold_pc_d;

  logic [ADDRESS_SIZE-1:0] pc;
  logic                    pc_load;
  logic                    pc_inc;
  logic                    slot_free;

  fetch_pc #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .RESET_PC     (RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load),
    .target_i (br_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  // The output slot can take a new word this edge if it is empty or being consumed.
  assign slot_free = !valid_q || !dec_stall;

  // Next-state, output-slot and PC control; redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    squash_d  = squash_q;
    valid_d   = valid_q && !slot_free;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!mem_busy) state_d = WAIT;
      end
      WAIT: begin
        if (!mem_busy) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            pc_inc = 1'b1;
            if (slot_free) begin
              inst_d    = mem_d_out;
              inst_pc_d = pc;
              valid_d   = 1'b1;
              state_d   = REQ;
            end else begin
              hold_d    = mem_d_out;
              hold_pc_d = pc;
              state_d   = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          inst_d    = hold_q;
          inst_pc_d = hold_pc_q;
          valid_d   = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (br_taken) begin
      pc_load   = 1'b1;
      pc_inc    = 1'b0;
      valid_d   = 1'b0;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      hold_d    = hold_q;
      hold_pc_d = hold_pc_q;
      // A read still outstanding must be allowed to return and then be dropped;
      // if its data lands on this very edge it is simply discarded.
      if (state_q == WAIT && mem_busy) begin
        squash_d = 1'b1;
        state_d  = WAIT;
      end else begin
        squash_d = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  // State, squash flag and output/hold registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      squash_q  <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      hold_q    <= '0;
      hold_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      squash_q  <= squash_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
    end
  end

  assign mem_en       = (state_q == REQ);
  assign mem_addr     = pc;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = ACCESS_SIZE'(ACC_WORD);
  assign inst_valid   = valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by random memory latency,
// decode stalls, redirects and resets, checked against an in-order stream model.
module tb_inst_fetch;

  localparam logic [31:0] RPC = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_wren;
  logic [1:0]  mem_acc_size;
  logic [31:0] mem_d_out;
  logic        mem_busy  = 1'b0;
  logic        br_taken  = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        dec_stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_errs   = 0;
  int n_cons   = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_en       (mem_en),
    .mem_wren     (mem_wren),
    .mem_acc_size (mem_acc_size),
    .mem_d_out    (mem_d_out),
    .mem_busy     (mem_busy),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .dec_stall    (dec_stall),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory: latch the accepted address, return its word whenever not busy.
  logic [31:0] lat_addr = 32'h0;
  always @(posedge clk) if (mem_en && !mem_busy) lat_addr <= mem_addr;
  assign mem_d_out = mem_busy ? ~mem_word(lat_addr) : mem_word(lat_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: requests walk sequentially from the last redirect/reset target,
  // and decode must consume exactly that sequence of (pc, word) pairs.
  logic [31:0] exp_req, exp_cons;
  logic        p_en, p_busy, p_valid, p_stall, p_br;
  logic [31:0] p_addr, p_inst, p_ipc, p_tgt;

  task automatic model_step();
    if (p_en) begin
      chk("req_addr", p_addr, exp_req);
      if (!p_busy) exp_req = p_addr + 32'd4;
    end
    if (p_valid && !p_stall) begin
      chk("cons_pc", p_ipc, exp_cons);
      chk("cons_word", p_inst, mem_word(p_ipc));
      exp_cons = p_ipc + 32'd4;
      n_cons++;
    end
    if (p_br) begin
      exp_req  = p_tgt & ~32'd3;
      exp_cons = p_tgt & ~32'd3;
      chk("flush_valid", 32'(inst_valid), 32'd0);
    end else if (p_valid && p_stall) begin
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, p_inst);
      chk("stall_pc", inst_pc, p_ipc);
    end
    if (mem_en) chk("bus_const", {29'd0, mem_wren, mem_acc_size}, 32'd0);
  endtask

  // Drive inputs for the next edge, remember the pre-edge view, then check after it.
  task automatic tick(input logic b, input logic s, input logic br, input logic [31:0] t);
    mem_busy = b; dec_stall = s; br_taken = br; br_target = t;
    p_en = mem_en; p_addr = mem_addr; p_busy = b; p_valid = inst_valid;
    p_inst = inst; p_ipc = inst_pc; p_stall = s; p_br = br; p_tgt = t;
    @(negedge clk);
    model_step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_ipc", inst_pc, 32'd0);
    chk("rst_addr", mem_addr, RPC);
    @(negedge clk);
    rst = 1'b0;
    mem_busy = 1'b0; dec_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    exp_req  = RPC;
    exp_cons = RPC;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!mem_en && n < 20) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk(tag, 32'(mem_en), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] a0, i0, pc0;
    @(negedge clk);
    do_reset();

    // 1: zero-wait streaming from the reset PC, one word every two cycles.
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t1_en", 32'(mem_en), 32'(k % 2 == 0));
      chk("t1_valid", 32'(inst_valid), 32'(k >= 2 && k % 2 == 0));
      if (k % 2 == 0) chk("t1_addr", mem_addr, RPC + 32'(4 * (k / 2)));
      if (inst_valid) begin
        chk("t1_ipc", inst_pc, RPC + 32'(4 * (k / 2 - 1)));
        chk("t1_inst", inst, mem_word(RPC + 32'(4 * (k / 2 - 1))));
      end
    end

    // 2: memory busy while requesting holds the request steady.
    wait_en("t2_wait_en");
    a0 = mem_addr;
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t2_en", 32'(mem_en), 32'd1);
      chk("t2_addr", mem_addr, a0);
    end

    // 3: decode stall freezes the output and parks the fetch.
    wait_valid("t3_wait_valid");
    i0 = inst; pc0 = inst_pc;
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t3_valid", 32'(inst_valid), 32'd1);
      chk("t3_inst", inst, i0);
      chk("t3_ipc", inst_pc, pc0);
      if (j >= 2) chk("t3_no_req", 32'(mem_en), 32'd0);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_rel_ipc", inst_pc, pc0 + 32'd4);
    chk("t3_rel_en", 32'(mem_en), 32'd1);
    chk("t3_rel_addr", mem_addr, inst_pc + 32'd4);

    // 4: redirect while a read is outstanding; that read must be dropped.
    wait_en("t4_wait_en");
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 32'h8002_0103);
    chk("t4_flush", 32'(inst_valid), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    wait_en("t4_wait_en2");
    chk("t4_addr", mem_addr, 32'h8002_0100);
    wait_valid("t4_wait_valid");
    chk("t4_ipc", inst_pc, 32'h8002_0100);

    // 5: redirect on the same edge as the data return.
    wait_en("t5_wait_en");
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h8003_0040);
    chk("t5_valid", 32'(inst_valid), 32'd0);
    chk("t5_idle", 32'(mem_en), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_en", 32'(mem_en), 32'd1);
    chk("t5_addr", mem_addr, 32'h8003_0040);

    // 6: PC wrap at the top of the address space, then reset during a read.
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    wait_en("t6_wait_en");
    chk("t6_top", mem_addr, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_wrap", mem_addr, 32'h0);
    chk("t6_ipc", inst_pc, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_restart_en", 32'(mem_en), 32'd1);
    chk("t6_restart_addr", mem_addr, RPC);

    // Random traffic.
    n_cons = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        b, s, br;
      logic [31:0] t;
      b  = ($urandom_range(0, 2) == 0);
      s  = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      tick(b, s, br, t);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    chk("progress", 32'(n_cons >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
